sram_ctrl: RTL and testbench
============================

# sram_ctrl

Multi-cycle controller between the MEM stage and the external 16-bit asynchronous SRAM that holds data memory. It turns one 32-bit load/store per request into two sequenced 16-bit half-word accesses and translates the address. It drives `ready` low while busy, and the hazard/freeze logic uses that to stall every pipeline register until the access completes.

## Interface
- `WAIT_CYCLES`, 3: clock cycles each half-word phase is held; legal range 2..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request from MEM stage.
- `rd_en` in 1: load request from MEM stage.
- `address` in 32: byte address from EXE result.
- `write_data` in 32: store data (Rm value).
- `read_data` out 32: loaded word, registered.
- `ready` out 1: low while a request is pending and not yet done; feeds freeze.
- `SRAM_ADDR` out 18: half-word address to SRAM.
- `SRAM_DQ` inout 16: SRAM data bus; driven only during write phases, else high-Z.
- `SRAM_WE_N` out 1: active-low write strobe. SRAM CE_N/OE_N/UB_N/LB_N are tied low at top level.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. Phase counter `cnt` is 4 bits.
- IDLE: if `wr_en|rd_en`, latch the op (write wins if both are high) and go to LOW with `cnt`=0.
- LOW/HIGH: `cnt` increments each cycle. When `cnt`==WAIT_CYCLES-1, clear `cnt` and advance LOW→HIGH or HIGH→DONE.
- DONE: one cycle, then IDLE unconditionally.
- Address: `eff` = `address` - 1024 (see Configuration). Word index is `eff[18:2]`. `SRAM_ADDR` = {`eff[18:2]`, 0} in LOW and {`eff[18:2]`, 1} in HIGH, and 0 in IDLE/DONE. `eff[1:0]` is ignored. Out-of-range addresses wrap modulo 2^18 half-words with no error.
- Write:
  - `SRAM_DQ` = `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH.
  - `SRAM_WE_N` is low while `cnt` < WAIT_CYCLES-1 and high in the last cycle of each phase, so address and data hold past the WE rising edge.
- Read:
  - `SRAM_WE_N` stays high and `SRAM_DQ` is high-Z.
  - `read_data[15:0]` samples `SRAM_DQ` on the last LOW cycle, and `read_data[31:16]` on the last HIGH cycle.
  - `read_data` holds its value until the next read overwrites it. Writes do not alter it.
- `ready` = ~(`wr_en`|`rd_en`) | (state==DONE). It is combinational so the freeze takes effect in the request cycle.
- SRAM pin outputs decode only from the state, counter and latched-op registers, never from the request inputs.

## Timing
- Reset values (async, immediate):
  - state IDLE, `cnt` 0, `read_data` 0.
  - `SRAM_WE_N` 1, `SRAM_ADDR` 0, `SRAM_DQ` high-Z.
  - `ready` = ~(`wr_en`|`rd_en`).
- Request seen in IDLE at cycle 0: LOW occupies cycles 1..W, HIGH occupies W+1..2W, DONE is cycle 2W+1.
  - `ready` is low for cycles 0..2W and high in cycle 2W+1.
  - With W=3: `ready` is low for 7 cycles and `read_data` is valid in cycle 7.
- The pipeline is frozen while `ready` is low, so `address`, `write_data` and op are stable. The controller latches them at IDLE exit anyway.
- A request that drops mid-operation still completes. The access is not aborted.
- After DONE, a request present in the following IDLE cycle starts a new access with no bubble beyond that IDLE cycle.
- `rst` mid-access aborts immediately, with `SRAM_WE_N` high. A request still asserted after reset release restarts from LOW.

## Configuration
- `SRAM_CTRL_BASE_SUB_EN` defined: `eff` = `address` - 32'd1024, matching the data-memory base of the ISA memory map.
- Undefined: `eff` = `address`, with no subtraction (used for standalone SRAM bring-up).

## Structure
- Shared package:
  - state enum (IDLE/LOW/HIGH/DONE);
  - `DATA_MEM_BASE` = 32'd1024;
  - `SRAM_AW` = 18 and `SRAM_DW` = 16.
- Sub-module `sram_phase_counter`: holds `cnt`, with clear/enable and a terminal-count flag at WAIT_CYCLES-1. Everything else lives in the top FSM.

## Test plan
- Reset applied with `rd_en`=1 → `ready`=0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `read_data`=0. Release → read starts in LOW next cycle.
- Store `address`=1028, `write_data`=0xDEADBEEF, W=3, BASE_SUB on:
  - SRAM_ADDR 2 with DQ 0xBEEF, then 3 with DQ 0xDEAD;
  - WE_N low 2 cycles per phase;
  - `ready` low 7 cycles.
- Load `address`=1028 after that store, with the SRAM model → `read_data`=0xDEADBEEF exactly in cycle 7, held through the following IDLE.
- `wr_en`=`rd_en`=1 → write sequence executes and `read_data` is unchanged.
- `rst` pulsed in HIGH of a store → WE_N goes 1 immediately, DQ high-Z. Store of 0x12345678 to 1032 reissued → memory word 1032 reads 0x12345678.
- Back-to-back loads at 1024 and 2044 → second LOW starts one cycle after first DONE. SRAM_ADDR is 0/1, then 510/511.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
// SRAM_CTRL_BASE_SUB_EN makes eff_word() remove the data-memory base address.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;
  localparam int          SRAM_AW       = 18;
  localparam int          SRAM_DW       = 16;
  localparam int          WORD_AW       = SRAM_AW - 1;

  // Takes byte-address bits [18:2]; the base has no bits below 2 so the subtraction stays exact.
  function automatic logic [WORD_AW-1:0] eff_word(input logic [WORD_AW-1:0] addr_word);
`ifdef SRAM_CTRL_BASE_SUB_EN
    return addr_word - DATA_MEM_BASE[WORD_AW+1:2];
`else
    return addr_word;
`endif
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Per-phase cycle counter for sram_ctrl: clears on request, counts while enabled,
// flags the terminal count WAIT_CYCLES-1 and exposes its next value for registered decode.
module sram_phase_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt_next,
  output logic       tc
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [3:0] cnt_d;
  logic [3:0] cnt_q;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next = cnt_d;
  assign tc       = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sram_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two timed 16-bit SRAM accesses.
// Define SRAM_CTRL_BASE_SUB_EN to subtract the data-memory base from the byte address.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e              state_d, state_q;
  logic                op_wr_d, op_wr_q;
  logic [WORD_AW-1:0]  word_d, word_q;
  logic [31:0]         wdata_d, wdata_q;
  logic [31:0]         rdata_d, rdata_q;
  logic [SRAM_AW-1:0]  addr_d, addr_q;
  logic [SRAM_DW-1:0]  dq_d, dq_q;
  logic                dq_oe_d, dq_oe_q;
  logic                we_n_d, we_n_q;
  logic                in_phase;
  logic                cnt_clr;
  logic                tc;
  logic [3:0]          cnt_next;
  logic                unused_addr_bits;

  assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign cnt_clr  = !in_phase || tc;

  sram_phase_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (in_phase),
    .cnt_next (cnt_next),
    .tc       (tc)
  );

  // State sequencing, request latch and read-data capture.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en || rd_en) begin
          state_d = ST_LOW;
          op_wr_d = wr_en;
          word_d  = eff_word(address[18:2]);
          wdata_d = write_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (tc) begin
          state_d = ST_HIGH;
          if (!op_wr_q) begin
            rdata_d[15:0] = SRAM_DQ;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (tc) begin
          state_d = ST_DONE;
          if (!op_wr_q) begin
            rdata_d[31:16] = SRAM_DQ;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from next state/count so the pins come straight off flops.
  always_comb begin
    addr_d  = {SRAM_AW{1'b0}};
    dq_d    = {SRAM_DW{1'b0}};
    dq_oe_d = 1'b0;
    we_n_d  = 1'b1;
    case (state_d)
      ST_LOW: begin
        addr_d  = {word_d, 1'b0};
        dq_d    = wdata_d[15:0];
        dq_oe_d = op_wr_d;
        we_n_d  = !(op_wr_d && (cnt_next < LAST_CNT));
      end
      ST_HIGH: begin
        addr_d  = {word_d, 1'b1};
        dq_d    = wdata_d[31:16];
        dq_oe_d = op_wr_d;
        we_n_d  = !(op_wr_d && (cnt_next < LAST_CNT));
      end
      default: begin
        addr_d  = {SRAM_AW{1'b0}};
        dq_d    = {SRAM_DW{1'b0}};
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
      end
    endcase
  end

  // FSM and registered outputs; reset releases the bus and deasserts the write strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      word_q  <= {WORD_AW{1'b0}};
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= {SRAM_AW{1'b0}};
      dq_q    <= {SRAM_DW{1'b0}};
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      we_n_q  <= we_n_d;
    end
  end

  assign SRAM_DQ          = dq_oe_q ? dq_q : {SRAM_DW{1'bz}};
  assign SRAM_ADDR        = addr_q;
  assign SRAM_WE_N        = we_n_q;
  assign read_data        = rdata_q;
  assign ready            = ~(wr_en | rd_en) | (state_q == ST_DONE);
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed plus randomized bench for sram_ctrl with a behavioural SRAM and word-level memory model.
module tb_sram_ctrl;

  localparam int W = 3;
`ifdef SRAM_CTRL_BASE_SUB_EN
  localparam logic [31:0] BASE = 32'd1024;
`else
  localparam logic [31:0] BASE = 32'd0;
`endif
  localparam logic [15:0] PROBE = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [17:0] sram_addr;
  wire  [15:0] sram_dq;
  wire         sram_we_n;

  logic [15:0] sram [0:262143];
  logic        tb_sram_oe = 1'b0;
  logic        tb_probe = 1'b0;
  logic [31:0] model_mem [int];
  logic [31:0] rdata_m = 32'd0;
  int          n_checks = 0;
  int          n_errors = 0;

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ    (sram_dq),
    .SRAM_WE_N  (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: drives on reads (or a probe pattern to detect bus release), latches on WE_N rise.
  assign sram_dq = tb_probe ? PROBE : (tb_sram_oe ? sram[sram_addr] : 16'bz);

  always @(posedge sram_we_n) begin
    if (!rst && !$isunknown(sram_addr) && !$isunknown(sram_dq)) sram[sram_addr] <= sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] e;
    e = a - BASE;
    return int'((e / 32'd4) % 32'd131072);
  endfunction

  // One request starting in an IDLE cycle; checks every cycle through DONE. drop_at>0 releases the request at that cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd, input int drop_at);
    int wi;
    wi = word_of(a);
    wr_en = wr; rd_en = rd; address = a; write_data = wd;
    tb_sram_oe = rd && !wr;
    @(negedge clk);
    check("ready_req", 32'(ready), 32'd0);
    for (int c = 1; c <= 2*W+1; c++) begin
      int ph, k;
      @(posedge clk); #1;
      if (c == drop_at) begin wr_en = 1'b0; rd_en = 1'b0; end
      @(negedge clk);
      ph = (c - 1) / W;
      k  = (c - 1) % W;
      check("ready", 32'(ready), 32'(!(wr_en || rd_en) || (c == 2*W+1)));
      if (ph < 2) begin
        check("sram_addr", 32'(sram_addr), 32'(2*wi + ph));
        check("we_n", 32'(sram_we_n), 32'(!(wr && (k < W-1))));
        if (wr) check("dq_write", 32'(sram_dq), (ph == 0) ? {16'd0, wd[15:0]} : {16'd0, wd[31:16]});
      end else begin
        check("addr_done", 32'(sram_addr), 32'd0);
        check("we_n_done", 32'(sram_we_n), 32'd1);
      end
    end
    if (wr) model_mem[wi] = wd;
    else rdata_m = model_mem.exists(wi) ? model_mem[wi] : 32'd0;
    check("read_data_done", read_data, rdata_m);
    if (wr) begin
      tb_probe = 1'b1; #1;
      check("dq_release", 32'(sram_dq), 32'(PROBE));
      tb_probe = 1'b0;
    end
    tb_sram_oe = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;

    // Reset held with a load pending.
    rd_en = 1'b1; address = 32'd1028; tb_probe = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_z", 32'(sram_dq), 32'(PROBE));
    check("rst_rdata", read_data, 32'd0);
    tb_probe = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    access(1'b0, 1'b1, 32'd1028, 32'd0, 0);

    // Store then load of the same word.
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1028, 32'd0, 0);
    @(posedge clk); #1; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("rdata_hold", read_data, 32'hDEADBEEF);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_addr", 32'(sram_addr), 32'd0);

    // Both requests high: the write runs and read_data is untouched.
    @(posedge clk); #1;
    access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1040, 32'd0, 0);

    // Reset in the HIGH phase of a store, then reissue.
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1032; write_data = 32'hAAAA5555;
    repeat (W+2) @(posedge clk);
    @(negedge clk);
    check("abort_pre_we_n", 32'(sram_we_n), 32'd0);
    #1 rst = 1'b1;
    rdata_m = 32'd0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_addr", 32'(sram_addr), 32'd0);
    check("abort_rdata", read_data, 32'd0);
    tb_probe = 1'b1; #1;
    check("abort_dq_z", 32'(sram_dq), 32'(PROBE));
    tb_probe = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    access(1'b1, 1'b0, 32'd1032, 32'h12345678, 0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1032, 32'd0, 0);

    // Request dropped mid-access still completes.
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1100, 32'h0BADCAFE, 2);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1100, 32'd0, 3);

    // Back-to-back loads at the base and near the top of the first KB.
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1024, 32'h01020304, 0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd2044, 32'hF0E0D0C0, 0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1024, 32'd0, 0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd2044, 32'd0, 0);

    // Randomized mix of loads, stores and combined requests with idle gaps.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      int op;
      int gap;
      op  = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 2));
      d   = $urandom();
      if (n % 6 == 5) a = $urandom();
      else a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (gap > 0) begin
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      access(op != 1, op != 0, a, d, 0);
    end

    @(posedge clk); #1; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("final_rdata", read_data, rdata_m);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
